// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU inst/data to single-port SRAM arbiter:
// owner encoding, response-tag layout, read-latency legality and counter width.
package cpu_mem_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  localparam int PERF_CNT_W = 32;

  // One in-flight request; wr lets write completions return a zero rdata.
  typedef struct packed {
    logic vld;
    logic owner;
    logic wr;
  } tag_t;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_tag_pipe.sv
// mem_arb_tag_pipe: RD_LAT-deep shift register of request tags, aligned with
// the SRAM read latency so the last stage marks the cycle rdata is valid.
module mem_arb_tag_pipe
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [RD_LAT];

  // Tag shift register; reset drops every in-flight response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the core's inst and data ports onto one synchronous
// SRAM, data side first. Define MEM_ARB_PERF_EN to add grant/conflict counters.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_inst_cnt,
  output logic [PERF_CNT_W-1:0] perf_data_cnt,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt
`endif
);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("cpu_mem_arbiter: RD_LAT must be within 1..3");
    end
  endgenerate

  logic r_run;
  logic w_data_gnt;
  logic w_inst_gnt;
  tag_t w_tag_in;
  tag_t w_tag_out;

  // Grants open on the first clock edge after reset release, not before
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Data wins: its request belongs to the older instruction in the pipeline.
  assign w_data_gnt   = r_run & data_req;
  assign w_inst_gnt   = r_run & inst_req & ~data_req;
  assign data_addr_ok = w_data_gnt;
  assign inst_addr_ok = w_inst_gnt;

  // Steer the granted master onto the SRAM port in the accept cycle
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = {AW{1'b0}};
    sram_wdata = 32'h0000_0000;
    if (w_data_gnt) begin
      sram_en   = 1'b1;
      sram_addr = data_addr;
      if (data_wr) begin
        sram_we    = data_wstrb;
        sram_wdata = data_wdata;
      end else begin
        sram_we    = 4'b0000;
        sram_wdata = 32'h0000_0000;
      end
    end else if (w_inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end else begin
      sram_en = 1'b0;
    end
  end

  // Tag for the request accepted this cycle
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.vld   = w_data_gnt | w_inst_gnt;
    w_tag_in.owner = w_data_gnt ? OWN_DATA : OWN_INST;
    w_tag_in.wr    = w_data_gnt & data_wr;
  end

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .resetn (resetn),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  // Route the matured response to its owner; everything else idles at zero
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0000_0000;
    data_rdata   = 32'h0000_0000;
    if (w_tag_out.vld) begin
      if (w_tag_out.owner == OWN_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = w_tag_out.wr ? 32'h0000_0000 : sram_rdata;
      end else begin
        inst_data_ok = 1'b1;
        inst_rdata   = sram_rdata;
      end
    end else begin
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

`ifdef MEM_ARB_PERF_EN
  localparam logic [PERF_CNT_W-1:0] PERF_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  logic [PERF_CNT_W-1:0] r_perf_inst_cnt;
  logic [PERF_CNT_W-1:0] r_perf_data_cnt;
  logic [PERF_CNT_W-1:0] r_perf_conflict_cnt;

  // Grant and conflict counters, wrapping naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_inst_cnt     <= {PERF_CNT_W{1'b0}};
      r_perf_data_cnt     <= {PERF_CNT_W{1'b0}};
      r_perf_conflict_cnt <= {PERF_CNT_W{1'b0}};
    end else begin
      if (w_inst_gnt) begin
        r_perf_inst_cnt <= r_perf_inst_cnt + PERF_ONE;
      end
      if (w_data_gnt) begin
        r_perf_data_cnt <= r_perf_data_cnt + PERF_ONE;
      end
      if (r_run & inst_req & data_req) begin
        r_perf_conflict_cnt <= r_perf_conflict_cnt + PERF_ONE;
      end
    end
  end

  assign perf_inst_cnt     = r_perf_inst_cnt;
  assign perf_data_cnt     = r_perf_data_cnt;
  assign perf_conflict_cnt = r_perf_conflict_cnt;
`else
  // Counter-free build: no extra state or ports.
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small behavioural SRAM whose word at index i holds 0x1000_0000+i.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // ---------------- instance A: RD_LAT = 1 ----------------
  logic        a_resetn, a_inst_req, a_inst_addr_ok, a_inst_data_ok;
  logic [31:0] a_inst_addr, a_inst_rdata;
  logic        a_data_req, a_data_wr, a_data_addr_ok, a_data_data_ok;
  logic [3:0]  a_data_wstrb, a_sram_we;
  logic [31:0] a_data_addr, a_data_wdata, a_data_rdata;
  logic        a_sram_en;
  logic [31:0] a_sram_addr, a_sram_wdata, a_sram_rdata;
  logic [31:0] a_mem [1024];
`ifdef MEM_ARB_PERF_EN
  logic [31:0] a_perf_inst, a_perf_data, a_perf_conf;
  logic [31:0] b_perf_inst, b_perf_data, b_perf_conf;
`endif

  cpu_mem_arbiter #(.RD_LAT(1), .AW(32)) dut_a (
    .clk(clk), .resetn(a_resetn),
    .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_addr_ok(a_inst_addr_ok),
    .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
    .data_req(a_data_req), .data_wr(a_data_wr), .data_wstrb(a_data_wstrb),
    .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_addr_ok(a_data_addr_ok),
    .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
    .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
    .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_inst_cnt(a_perf_inst), .perf_data_cnt(a_perf_data), .perf_conflict_cnt(a_perf_conf)
`endif
  );

  always @(posedge clk) begin
    if (a_sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (a_sram_we[i]) a_mem[a_sram_addr[11:2]][8*i +: 8] <= a_sram_wdata[8*i +: 8];
      end
      a_sram_rdata <= a_mem[a_sram_addr[11:2]];
    end
  end

  // ---------------- instance B: RD_LAT = 3 ----------------
  logic        b_resetn, b_inst_req, b_inst_addr_ok, b_inst_data_ok;
  logic [31:0] b_inst_addr, b_inst_rdata;
  logic        b_data_req, b_data_wr, b_data_addr_ok, b_data_data_ok;
  logic [3:0]  b_data_wstrb, b_sram_we;
  logic [31:0] b_data_addr, b_data_wdata, b_data_rdata;
  logic        b_sram_en;
  logic [31:0] b_sram_addr, b_sram_wdata, b_sram_rdata, b_p1, b_p2;
  logic [31:0] b_mem [1024];

  cpu_mem_arbiter #(.RD_LAT(3), .AW(32)) dut_b (
    .clk(clk), .resetn(b_resetn),
    .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(b_inst_addr_ok),
    .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
    .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
    .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(b_data_addr_ok),
    .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_inst_cnt(b_perf_inst), .perf_data_cnt(b_perf_data), .perf_conflict_cnt(b_perf_conf)
`endif
  );

  always @(posedge clk) begin
    if (b_sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (b_sram_we[i]) b_mem[b_sram_addr[11:2]][8*i +: 8] <= b_sram_wdata[8*i +: 8];
      end
    end
    b_p1         <= b_sram_en ? b_mem[b_sram_addr[11:2]] : 32'h0;
    b_p2         <= b_p1;
    b_sram_rdata <= b_p2;
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 32'h1000_0000 + 32'(i);
      b_mem[i] = 32'h1000_0000 + 32'(i);
    end
    a_mem[128] = 32'h0;
    a_resetn = 1'b0; a_inst_req = 1'b0; a_inst_addr = 32'h0; a_data_req = 1'b0;
    a_data_wr = 1'b0; a_data_wstrb = 4'h0; a_data_addr = 32'h0; a_data_wdata = 32'h0;
    b_resetn = 1'b0; b_inst_req = 1'b0; b_inst_addr = 32'h0; b_data_req = 1'b0;
    b_data_wr = 1'b0; b_data_wstrb = 4'h0; b_data_addr = 32'h0; b_data_wdata = 32'h0;

    // reset holds everything idle even with requests pending
    repeat (2) @(posedge clk);
    #1 a_inst_req = 1'b1; a_data_req = 1'b1; b_inst_req = 1'b1;
    @(negedge clk);
    check("rst_a_addr_ok", 32'({a_inst_addr_ok, a_data_addr_ok}), 32'h0);
    check("rst_a_sram_en", 32'(a_sram_en), 32'h0);
    check("rst_a_data_ok", 32'({a_inst_data_ok, a_data_data_ok}), 32'h0);
    check("rst_b_sram_en", 32'(b_sram_en), 32'h0);
    a_data_req = 1'b0; b_inst_req = 1'b0;
    a_resetn = 1'b1; b_resetn = 1'b1;
    #1 check("rel_no_early_gnt", 32'(a_inst_addr_ok), 32'h0);
    a_inst_req = 1'b0;

    // 16 back-to-back inst reads, RD_LAT=1
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      a_inst_req  = (k < 16);
      a_inst_addr = 32'h1c00_0000 + 32'(4 * k);
      @(negedge clk);
      check("t1_addr_ok", 32'(a_inst_addr_ok), 32'(k < 16));
      check("t1_data_ok", 32'(a_inst_data_ok), 32'(k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) check("t1_rdata", a_inst_rdata, 32'h1000_0000 + 32'(k - 1));
    end

    // simultaneous requests: data first, inst next
    @(posedge clk); #1;
    a_data_req = 1'b1; a_data_wr = 1'b0; a_data_addr = 32'h0000_0100;
    a_inst_req = 1'b1; a_inst_addr = 32'h1c00_0000;
    @(negedge clk);
    check("t2_gnt_data", 32'({a_inst_addr_ok, a_data_addr_ok}), 32'h1);
    check("t2_sram_addr", a_sram_addr, 32'h0000_0100);
    @(posedge clk); #1; a_data_req = 1'b0;
    @(negedge clk);
    check("t2_gnt_inst", 32'({a_inst_addr_ok, a_data_addr_ok}), 32'h2);
    check("t2_resp_data", 32'({a_inst_data_ok, a_data_data_ok}), 32'h1);
    check("t2_data_rdata", a_data_rdata, 32'h1000_0040);
    @(posedge clk); #1; a_inst_req = 1'b0;
    @(negedge clk);
    check("t2_resp_inst", 32'({a_inst_data_ok, a_data_data_ok}), 32'h2);
    check("t2_inst_rdata", a_inst_rdata, 32'h1000_0000);

    // partial write then read back
    @(posedge clk); #1;
    a_data_req = 1'b1; a_data_wr = 1'b1; a_data_wstrb = 4'b0011;
    a_data_addr = 32'h0000_0200; a_data_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("t3_wr_acc", 32'(a_data_addr_ok), 32'h1);
    check("t3_sram_we", 32'(a_sram_we), 32'h3);
    @(posedge clk); #1; a_data_wr = 1'b0; a_data_wstrb = 4'b0000;
    @(negedge clk);
    check("t3_rd_acc", 32'(a_data_addr_ok), 32'h1);
    check("t3_rd_we", 32'(a_sram_we), 32'h0);
    check("t3_wr_done", 32'(a_data_data_ok), 32'h1);
    check("t3_wr_rdata", a_data_rdata, 32'h0);
    @(posedge clk); #1; a_data_req = 1'b0;
    @(negedge clk);
    check("t3_rd_ok", 32'(a_data_data_ok), 32'h1);
    check("t3_rd_rdata", a_data_rdata, 32'h0000_CCDD);

    // RD_LAT=3 alternating inst/data stream
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk); #1;
      b_inst_req  = (k < 8) && (k % 2 == 0);
      b_data_req  = (k < 8) && (k % 2 == 1);
      b_inst_addr = 32'h1c00_0000 + 32'(4 * k);
      b_data_addr = 32'h0000_0100 + 32'(4 * k);
      @(negedge clk);
      check("t4_acc", 32'({b_inst_addr_ok, b_data_addr_ok}),
            (k >= 8) ? 32'h0 : ((k % 2 == 0) ? 32'h2 : 32'h1));
      if (k >= 3 && k <= 10) begin
        if ((k - 3) % 2 == 0) begin
          check("t4_ok_inst", 32'({b_inst_data_ok, b_data_data_ok}), 32'h2);
          check("t4_inst_rdata", b_inst_rdata, 32'h1000_0000 + 32'(k - 3));
        end else begin
          check("t4_ok_data", 32'({b_inst_data_ok, b_data_data_ok}), 32'h1);
          check("t4_data_rdata", b_data_rdata, 32'h1000_0040 + 32'(k - 3));
        end
      end else begin
        check("t4_ok_idle", 32'({b_inst_data_ok, b_data_data_ok}), 32'h0);
      end
    end

    // reset with two reads in flight
    @(posedge clk); #1; b_data_req = 1'b1; b_data_addr = 32'h0000_0104;
    @(posedge clk); #1; b_data_addr = 32'h0000_0108;
    @(posedge clk); #1; b_data_req = 1'b0; b_inst_req = 1'b1; b_inst_addr = 32'h1c00_0000;
    #1 b_resetn = 1'b0;
    #1;
    check("t5_en_drop", 32'(b_sram_en), 32'h0);
    check("t5_acc_drop", 32'({b_inst_addr_ok, b_data_addr_ok}), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_no_resp", 32'({b_inst_data_ok, b_data_data_ok}), 32'h0);
    end
    b_inst_req = 1'b0;
    b_resetn   = 1'b1;
    @(posedge clk); #1; b_data_req = 1'b1; b_data_addr = 32'h0000_010c;
    @(negedge clk);
    check("t5_post_acc", 32'(b_data_addr_ok), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; b_data_req = 1'b0;
      @(negedge clk);
      check("t5_post_ok", 32'(b_data_data_ok), 32'(k == 3));
      if (k == 3) check("t5_post_rdata", b_data_rdata, 32'h1000_0043);
    end

    // grant/conflict sequence on A after a fresh reset
    a_resetn = 1'b0;
    @(negedge clk);
    a_resetn = 1'b1;
`ifdef MEM_ARB_PERF_EN
    check("perf_rst", a_perf_inst | a_perf_data | a_perf_conf, 32'h0);
`endif
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      a_data_req  = (k < 7);
      a_inst_req  = (k < 5) || (k >= 7);
      a_data_addr = 32'h0000_0100 + 32'(4 * k);
      a_inst_addr = 32'h1c00_0000;
      @(negedge clk);
      check("t6_gnt", 32'({a_inst_addr_ok, a_data_addr_ok}), (k < 7) ? 32'h1 : 32'h2);
    end
    @(posedge clk); #1; a_data_req = 1'b0; a_inst_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check("perf_conflict", a_perf_conf, 32'd5);
    check("perf_data", a_perf_data, 32'd7);
    check("perf_inst", a_perf_inst, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
